fft_reorder: RTL and testbench

FFT_REORDER -- requirements
Module: fft_reorder

---
 rtl/fft_reorder_pkg.sv | 22 ++
 rtl/fft_reorder_bank.sv | 39 +++
 rtl/fft_reorder.sv | 142 ++++++++++++++
 tb/tb_fft_reorder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_reorder_pkg.sv
// Shared FFT definitions: frame geometry defaults, reorder FSM states and the
// 9-bit bit-reversal used to map natural-order bins onto bit-reversed points.
package fft_reorder_pkg;

  localparam int unsigned FFT_DATA_WIDTH  = 13;
  localparam int unsigned FFT_N           = 16;
  localparam int unsigned FFT_FRAME_BEATS = 32;

  typedef enum logic {
    StIdle,
    StRead
  } rd_state_e;

  function automatic logic [8:0] bitrev9(input logic [8:0] x);
    logic [8:0] y;
    for (int i = 0; i < 9; i++) begin
      y[i] = x[8-i];
    end
    return y;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame of complex samples: written a whole beat at a time, read back with
// each output lane scattered to its bit-reversed source beat and lane.
module reorder_bank
  import fft_reorder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = FFT_DATA_WIDTH,
  parameter int unsigned N           = FFT_N,
  parameter int unsigned FRAME_BEATS = FFT_FRAME_BEATS
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [4:0]                   wr_beat_i,
  input  logic signed [DATA_WIDTH-1:0] wr_re_i [0:N-1],
  input  logic signed [DATA_WIDTH-1:0] wr_im_i [0:N-1],
  input  logic [4:0]                   rd_beat_i,
  output logic signed [DATA_WIDTH-1:0] rd_re_o [0:N-1],
  output logic signed [DATA_WIDTH-1:0] rd_im_o [0:N-1]
);

  logic signed [DATA_WIDTH-1:0] mem_re [0:FRAME_BEATS-1][0:N-1];
  logic signed [DATA_WIDTH-1:0] mem_im [0:FRAME_BEATS-1][0:N-1];

  // Contents are never reset; a frame is only read after being fully written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_re[wr_beat_i] <= wr_re_i;
      mem_im[wr_beat_i] <= wr_im_i;
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [8:0] src;
    // src[8:4] = {j0,j1,j2,j3,r0} source beat, src[3:0] = {r1..r4} source lane
    assign src        = bitrev9({rd_beat_i, 4'(j)});
    assign rd_re_o[j] = mem_re[src[8:4]][src[3:0]];
    assign rd_im_o[j] = mem_im[src[8:4]][src[3:0]];
  end

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer turning bit-reversed FFT output beats into
// natural-order beats, with back-to-back frames streamed without gaps.
module fft_reorder
  import fft_reorder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = FFT_DATA_WIDTH,
  parameter int unsigned N           = FFT_N,
  parameter int unsigned FRAME_BEATS = FFT_FRAME_BEATS
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] din_i [0:N-1],
  input  logic signed [DATA_WIDTH-1:0] din_q [0:N-1],
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] dout_i [0:N-1],
  output logic signed [DATA_WIDTH-1:0] dout_q [0:N-1]
);

  localparam logic [4:0] LastBeat = 5'(FRAME_BEATS - 1);

  logic [4:0] wr_cnt_q;
  logic       wr_bank_q;
  logic [1:0] ready_q, ready_d;
  rd_state_e  state_q, state_d;
  logic [4:0] rd_beat_q, rd_beat_d;
  logic       rd_bank_q, rd_bank_d;
  logic       consume;
  logic       wr_wrap;

  logic signed [DATA_WIDTH-1:0] rd_re0 [0:N-1];
  logic signed [DATA_WIDTH-1:0] rd_im0 [0:N-1];
  logic signed [DATA_WIDTH-1:0] rd_re1 [0:N-1];
  logic signed [DATA_WIDTH-1:0] rd_im1 [0:N-1];

  assign wr_wrap = valid_in && (wr_cnt_q == LastBeat);

  reorder_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .FRAME_BEATS(FRAME_BEATS)
  ) u_bank0 (
    .clk_i    (clk),
    .we_i     (valid_in && !wr_bank_q),
    .wr_beat_i(wr_cnt_q),
    .wr_re_i  (din_i),
    .wr_im_i  (din_q),
    .rd_beat_i(rd_beat_q),
    .rd_re_o  (rd_re0),
    .rd_im_o  (rd_im0)
  );

  reorder_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .FRAME_BEATS(FRAME_BEATS)
  ) u_bank1 (
    .clk_i    (clk),
    .we_i     (valid_in && wr_bank_q),
    .wr_beat_i(wr_cnt_q),
    .wr_re_i  (din_i),
    .wr_im_i  (din_q),
    .rd_beat_i(rd_beat_q),
    .rd_re_o  (rd_re1),
    .rd_im_o  (rd_im1)
  );

  // Frames alternate banks, so the next frame to read is always ~rd_bank_q.
  always_comb begin
    state_d   = state_q;
    rd_beat_d = rd_beat_q;
    rd_bank_d = rd_bank_q;
    consume   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ready_q[~rd_bank_q]) begin
          state_d   = StRead;
          rd_bank_d = ~rd_bank_q;
          rd_beat_d = '0;
          consume   = 1'b1;
        end
      end
      StRead: begin
        rd_beat_d = rd_beat_q + 5'd1;
        if (rd_beat_q == LastBeat) begin
          rd_beat_d = '0;
          if (ready_q[~rd_bank_q]) begin
            rd_bank_d = ~rd_bank_q;
            consume   = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    ready_d = ready_q;
    if (consume) ready_d[~rd_bank_q] = 1'b0;
    if (wr_wrap) ready_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      ready_q   <= '0;
      state_q   <= StIdle;
      rd_beat_q <= '0;
      rd_bank_q <= 1'b1;
    end else begin
      if (valid_in) wr_cnt_q <= wr_cnt_q + 5'd1;
      if (wr_wrap) wr_bank_q <= ~wr_bank_q;
      ready_q   <= ready_d;
      state_q   <= state_d;
      rd_beat_q <= rd_beat_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      for (int l = 0; l < int'(N); l++) begin
        dout_i[l] <= '0;
        dout_q[l] <= '0;
      end
    end else if (state_q == StRead) begin
      valid_out <= 1'b1;
      if (rd_bank_q) begin
        dout_i <= rd_re1;
        dout_q <= rd_im1;
      end else begin
        dout_i <= rd_re0;
        dout_q <= rd_im0;
      end
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// Bench for fft_reorder: drives whole frames, captures every output beat with
// its edge number, and compares against a bit-reversal model of each frame.
module tb_fft_reorder;

  typedef logic [15:0][12:0] pbeat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic valid_in = 1'b0;
  logic signed [12:0] din_i [0:15];
  logic signed [12:0] din_q [0:15];
  logic valid_out;
  logic signed [12:0] dout_i [0:15];
  logic signed [12:0] dout_q [0:15];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [12:0] fi [512];
  logic [12:0] fq [512];

  pbeat_t cap_i[$], cap_q[$], exp_i[$], exp_q[$];
  int     cap_t[$];

  fft_reorder dut (
    .clk      (clk),
    .rstn     (rstn),
    .valid_in (valid_in),
    .din_i    (din_i),
    .din_q    (din_q),
    .valid_out(valid_out),
    .dout_i   (dout_i),
    .dout_q   (dout_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out) begin
      pbeat_t bi, bq;
      for (int l = 0; l < 16; l++) begin
        bi[l] = dout_i[l];
        bq[l] = dout_q[l];
      end
      cap_i.push_back(bi);
      cap_q.push_back(bq);
      cap_t.push_back(cyc);
    end
  end

  function automatic int brev9(input int k);
    int r = 0;
    for (int i = 0; i < 9; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  function automatic pbeat_t cur_out_i();
    pbeat_t b;
    for (int l = 0; l < 16; l++) b[l] = dout_i[l];
    return b;
  endfunction

  function automatic pbeat_t cur_out_q();
    pbeat_t b;
    for (int l = 0; l < 16; l++) b[l] = dout_q[l];
    return b;
  endfunction

  task automatic fill_index();
    for (int p = 0; p < 512; p++) begin
      fi[p] = 13'(p);
      fq[p] = 13'(-p);
    end
  endtask

  task automatic fill_random();
    for (int p = 0; p < 512; p++) begin
      fi[p] = 13'($urandom);
      fq[p] = 13'($urandom);
    end
  endtask

  // Output bin k = r*16+j comes from input point bitrev(k).
  task automatic push_expected();
    pbeat_t ei, eq;
    for (int r = 0; r < 32; r++) begin
      for (int j = 0; j < 16; j++) begin
        ei[j] = fi[brev9(r * 16 + j)];
        eq[j] = fq[brev9(r * 16 + j)];
      end
      exp_i.push_back(ei);
      exp_q.push_back(eq);
    end
  endtask

  task automatic clear_queues();
    cap_i.delete(); cap_q.delete(); cap_t.delete();
    exp_i.delete(); exp_q.delete();
  endtask

  // mode 0: full rate, 1: one idle cycle between beats, 2: random 0..3 idle cycles
  task automatic drive_frame(input int mode, input int nbeats, output int t_last);
    t_last = -1;
    for (int b = 0; b < nbeats; b++) begin
      int gaps;
      @(negedge clk);
      valid_in = 1'b1;
      for (int l = 0; l < 16; l++) begin
        din_i[l] = fi[b * 16 + l];
        din_q[l] = fq[b * 16 + l];
      end
      if (b == nbeats - 1) t_last = cyc + 1;
      gaps = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
      if (b != nbeats - 1) begin
        repeat (gaps) begin
          @(negedge clk);
          valid_in = 1'b0;
          for (int l = 0; l < 16; l++) begin
            din_i[l] = 13'($urandom);
            din_q[l] = 13'($urandom);
          end
        end
      end
    end
    if (nbeats == 32) push_expected();
  endtask

  task automatic go_idle();
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cap_i.size() >= n) break;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int l = 0; l < 16; l++) begin
      din_i[l] = '0;
      din_q[l] = '0;
    end
    repeat (3) @(negedge clk);
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", valid_out);
    end
    total++;
    if (cur_out_i() !== '0 || cur_out_q() !== '0) begin
      bad++; $display("FAIL reset_dout: got %h/%h want 0", cur_out_i(), cur_out_q());
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_data(input string name);
    total++;
    if (cap_i.size() !== exp_i.size()) begin
      bad++; $display("FAIL %s_count: got %0d beats want %0d", name, cap_i.size(), exp_i.size());
    end
    for (int i = 0; i < cap_i.size() && i < exp_i.size(); i++) begin
      total++;
      if (cap_i[i] !== exp_i[i] || cap_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s_beat%0d: got %h/%h want %h/%h", name, i, cap_i[i], cap_q[i],
                 exp_i[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_window(input string name, input int first, input int len);
    total++;
    if (cap_t.size() < len || cap_t[0] !== first || cap_t[len-1] !== first + len - 1) begin
      bad++;
      $display("FAIL %s_window: got start %0d end %0d n %0d want %0d..%0d", name,
               (cap_t.size() > 0) ? cap_t[0] : -1,
               (cap_t.size() >= len) ? cap_t[len-1] : -1, cap_t.size(), first, first + len - 1);
    end
  endtask

  task automatic test_full_rate();
    int t;
    clear_queues();
    fill_index();
    drive_frame(0, 32, t);
    go_idle();
    wait_out(32);
    check_window("full", t + 2, 32);
    check_data("full");
    total++;
    if (cap_i.size() > 0 && (cap_i[0][1] !== 13'd256 || cap_q[0][1] !== 13'h1F00)) begin
      bad++; $display("FAIL full_b0l1: got %0d/%0d want 256/-256", $signed(cap_i[0][1]),
                      $signed(cap_q[0][1]));
    end
    total++;
    if (cap_i.size() > 31 && (cap_i[31][15] !== 13'd511 || cap_q[31][15] !== 13'h1E01)) begin
      bad++; $display("FAIL full_b31l15: got %0d/%0d want 511/-511", $signed(cap_i[31][15]),
                      $signed(cap_q[31][15]));
    end
    total++;
    if (cap_i.size() > 0 && (cap_i[0][0] !== 13'd0 || cap_q[0][0] !== 13'd0)) begin
      bad++; $display("FAIL full_b0l0: got %0d/%0d want 0/0", $signed(cap_i[0][0]),
                      $signed(cap_q[0][0]));
    end
    total++;
    if (valid_out !== 1'b0 || cur_out_i() !== exp_i[31] || cur_out_q() !== exp_q[31]) begin
      bad++; $display("FAIL full_hold: got v=%b %h want v=0 %h", valid_out, cur_out_i(),
                      exp_i[31]);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t;
    clear_queues();
    for (int f = 0; f < 4; f++) begin
      fill_random();
      drive_frame(0, 32, t);
      if (f == 0) t0 = t;
    end
    go_idle();
    wait_out(128);
    check_window("b2b", t0 + 2, 128);
    check_data("b2b");
  endtask

  task automatic test_half_rate();
    int t;
    clear_queues();
    fill_index();
    drive_frame(1, 32, t);
    go_idle();
    wait_out(32);
    check_window("half", t + 2, 32);
    check_data("half");
  endtask

  task automatic test_random_gaps();
    int t0, t1;
    clear_queues();
    fill_random();
    drive_frame(2, 32, t0);
    fill_random();
    drive_frame(2, 32, t1);
    go_idle();
    wait_out(64);
    check_window("rgap0", t0 + 2, 32);
    total++;
    if (cap_t.size() < 64 || cap_t[32] !== t1 + 2 || cap_t[63] !== t1 + 33) begin
      bad++; $display("FAIL rgap1_window: got start %0d want %0d",
                      (cap_t.size() > 32) ? cap_t[32] : -1, t1 + 2);
    end
    check_data("rgap");
  endtask

  task automatic test_mid_reset();
    int t;
    clear_queues();
    fill_random();
    drive_frame(0, 20, t);
    @(negedge clk);
    valid_in = 1'b0;
    rstn = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0 || cur_out_i() !== '0 || cur_out_q() !== '0) begin
      bad++; $display("FAIL midrst_clear: got v=%b %h/%h want all 0", valid_out, cur_out_i(),
                      cur_out_q());
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    clear_queues();
    fill_index();
    drive_frame(0, 32, t);
    go_idle();
    wait_out(32);
    check_window("midrst", t + 2, 32);
    check_data("midrst");
  endtask

  task automatic test_extremes();
    int t;
    clear_queues();
    for (int p = 0; p < 512; p++) begin
      fi[p] = 13'h1000;
      fq[p] = 13'h0FFF;
    end
    drive_frame(0, 32, t);
    go_idle();
    wait_out(32);
    check_window("extreme", t + 2, 32);
    check_data("extreme");
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_back_to_back();
    test_half_rate();
    test_random_gaps();
    test_mid_reset();
    test_extremes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
